counter_prog: RTL
=================

COUNTER_PROG -- requirements
Module: counter_prog

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, meaning count and terminal-value width in bits (legal range 1..32).
REQ-002 SHALL provide parameter EVT_WIDTH, default 8, meaning width of the terminal-event counter (used only under REQ-030).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL provide port i_enable  input  1  count-step enable.
REQ-006 SHALL provide port i_clear  input  1  synchronous clear of count, done and event state.
REQ-007 SHALL provide port i_load  input  1  synchronous load of o_count from i_load_val.
REQ-008 SHALL provide port i_load_val  input  WIDTH  value loaded on i_load.
REQ-009 SHALL provide port i_max  input  WIDTH  runtime terminal value, sampled every cycle.
REQ-010 SHALL provide port i_oneshot  input  1  mode select: 1 = one-shot, 0 = periodic; sampled every cycle.
REQ-011 SHALL provide port o_count  output  WIDTH  current count, registered.
REQ-012 SHALL provide port o_tick  output  1  registered one-cycle terminal pulse.
REQ-013 SHALL provide port o_done  output  1  registered sticky one-shot completion flag.

Function
REQ-014 SHALL implement two states: RUN and DONE; reset state RUN.
REQ-015 SHALL apply per-cycle priority: i_clear, then i_load, then i_enable step.
REQ-016 SHALL, on i_clear, set o_count=0, o_done=0, state RUN, o_tick=0 next cycle, regardless of i_load/i_enable.
REQ-017 SHALL, on i_load without i_clear, set o_count=i_load_val, o_done=0, state RUN, o_tick=0 next cycle; load never generates a tick.
REQ-018 SHALL define a terminal step as: state RUN, i_enable=1, no clear/load, and o_count >= i_max (unsigned compare).
REQ-019 SHALL, on a non-terminal step in RUN, increment o_count by 1.
REQ-020 SHALL, on a terminal step with i_oneshot=0, set o_count=0 and remain in RUN.
REQ-021 SHALL, on a terminal step with i_oneshot=1, hold o_count at i_max, set o_done=1, enter DONE.
REQ-022 SHALL assert o_tick for exactly the one cycle following every terminal step; otherwise o_tick=0.
REQ-023 SHALL, in DONE, ignore i_enable and i_oneshot changes; leave DONE only via i_clear or i_load.
REQ-024 SHALL, with i_enable=0 in RUN, hold o_count and produce no tick.
REQ-025 SHALL treat i_max=0 in periodic mode as tick every enabled cycle, o_count constant 0.
REQ-026 SHALL, when i_max is lowered below o_count mid-run, take a terminal step on the next enabled cycle (no wrap through 2^WIDTH).
REQ-027 SHALL accept i_load_val > i_max; next enabled cycle is then a terminal step.
REQ-028 SHALL never let o_count wrap through 2^WIDTH-1; with i_max = all-ones, period is 2^WIDTH enabled cycles.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force o_count=0, o_tick=0, o_done=0, state RUN, and event counter 0; first step possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, when macro COUNTER_PROG_EVT_CNT_EN is defined, add output port o_evt_count (EVT_WIDTH bits, registered) incrementing by 1 on each terminal step, saturating at all-ones, cleared by i_clear and reset, unaffected by i_load.
REQ-031 SHALL, when COUNTER_PROG_EVT_CNT_EN is undefined, omit o_evt_count and all its logic; all other behaviour identical.

Verification
REQ-032 SHALL cover periodic: i_max=3, i_enable=1 held -> o_count 0,1,2,3,0,...; o_tick high one cycle after each count=3 cycle, period 4.
REQ-033 SHALL cover one-shot: i_oneshot=1, i_max=5 -> o_count stops at 5, one o_tick, o_done=1 sticky over 20 further enabled cycles; i_load 0 -> o_done=0, counting resumes.
REQ-034 SHALL cover priority: i_clear, i_load (val 9) and i_enable all high in one cycle -> o_count=0, o_tick=0 next cycle; i_load+i_enable only -> o_count=9, no tick.
REQ-035 SHALL cover runtime max change: count at 10, i_max changed 20->4 -> next enabled cycle wraps to 0 with one tick; i_max=0 -> tick every enabled cycle.
REQ-036 SHALL cover reset mid-run: rst_n asserted asynchronously mid-cycle at count 7 with o_done=1 -> all outputs 0 immediately, before next clock edge.
REQ-037 SHALL cover, with COUNTER_PROG_EVT_CNT_EN and EVT_WIDTH=2, i_max=0: o_evt_count 1,2,3,3 (saturated); i_clear -> 0.

Source files
------------

// File: rtl/counter_prog.sv
//------------------------------------------------------------------------------
// Module  : counter_prog
// Brief   : Programmable up-counter with runtime terminal value, periodic or
//           one-shot mode, registered terminal tick and sticky done flag.
//           Define COUNTER_PROG_EVT_CNT_EN to add the saturating o_evt_count.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter_prog #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned EVT_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [WIDTH-1:0] i_max,
  input  logic             i_oneshot,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tick,
  output logic             o_done
`ifdef COUNTER_PROG_EVT_CNT_EN
  ,
  output logic [EVT_WIDTH-1:0] o_evt_count
`endif
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_tick;
  logic             w_tick_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_terminal;

  if ((WIDTH < 1) || (WIDTH > 32) || (EVT_WIDTH < 1)) begin : g_param_check
    $error("counter_prog: WIDTH must be 1..32 and EVT_WIDTH at least 1");
  end

  // Compare with >= so a lowered i_max or an oversized load ends the period
  // on the next enabled cycle instead of wrapping through 2^WIDTH.
  assign w_terminal = (r_state == ST_RUN) && i_enable && !i_clear && !i_load
                      && (r_count >= i_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_tick  <= w_tick_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = r_done;

    if (i_clear) begin
      w_state_nxt = ST_RUN;
      w_count_nxt = '0;
      w_done_nxt  = 1'b0;
    end else if (i_load) begin
      w_state_nxt = ST_RUN;
      w_count_nxt = i_load_val;
      w_done_nxt  = 1'b0;
    end else if (w_terminal) begin
      w_tick_nxt = 1'b1;
      if (i_oneshot) begin
        w_state_nxt = ST_DONE;
        w_count_nxt = i_max;
        w_done_nxt  = 1'b1;
      end else begin
        w_count_nxt = '0;
      end
    end else if ((r_state == ST_RUN) && i_enable) begin
      // r_count < i_max here, so the increment cannot overflow.
      w_count_nxt = r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_tick  = r_tick;
  assign o_done  = r_done;

`ifdef COUNTER_PROG_EVT_CNT_EN
  logic [EVT_WIDTH-1:0] r_evt_count;
  logic [EVT_WIDTH-1:0] w_evt_count_nxt;

  always_comb begin
    w_evt_count_nxt = r_evt_count;
    if (i_clear) begin
      w_evt_count_nxt = '0;
    end else if (w_terminal && (r_evt_count != {EVT_WIDTH{1'b1}})) begin
      w_evt_count_nxt = r_evt_count + EVT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_count <= '0;
    end else begin
      r_evt_count <= w_evt_count_nxt;
    end
  end

  assign o_evt_count = r_evt_count;
`endif

endmodule

`default_nettype wire
